// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer bus: control inputs, ROM data, PC/Instr/status outputs
interface fetch_sequencer_if #(
   parameter int PCW  = 10,
   parameter int IW   = 9,
   parameter int CNTW = 16
);
   logic            i_start;
   logic [IW-1:0]   i_rom_data;
   logic            i_branch;
   logic            i_jump;
   logic            i_taken;
   logic [PCW-1:0]  i_target;
   logic            i_stall;
   logic [PCW-1:0]  o_pc;
   logic [IW-1:0]   o_instr;
   logic            o_instr_valid;
   logic            o_done;
   logic [CNTW-1:0] o_cycle_cnt;

   modport master (
      output i_start, i_rom_data, i_branch, i_jump, i_taken, i_target, i_stall,
      input  o_pc, o_instr, o_instr_valid, o_done, o_cycle_cnt
   );

   modport slave (
      input  i_start, i_rom_data, i_branch, i_jump, i_taken, i_target, i_stall,
      output o_pc, o_instr, o_instr_valid, o_done, o_cycle_cnt
   );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch / PC sequencer with Start/Done run bracketing
// Next-PC is registered; Instr is forwarded combinationally so the decoder sees it with zero latency.
module fetch_sequencer #(
   parameter int            PCW  = 10,
   parameter int            IW   = 9,
   parameter logic [IW-1:0] HALT = 9'h1FF,
   parameter int            CNTW = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   fetch_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [PCW-1:0]  r_pc;
   logic            r_done;
   logic [CNTW-1:0] r_cycle_cnt;
   logic            w_run;

   assign w_run = (r_state == S_RUN);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_done      <= 1'b0;
         r_cycle_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_state     <= S_RUN;
                  r_pc        <= '0;
                  r_cycle_cnt <= '0;
               end
            end
            S_RUN: begin
               // Counts stalled and HALT cycles too; saturates at all-ones.
               if (r_cycle_cnt != {CNTW{1'b1}})
                  r_cycle_cnt <= r_cycle_cnt + CNTW'(1);
               if (bus.i_stall) begin
                  r_pc <= r_pc;
               end else if (bus.i_rom_data == HALT) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else if (bus.i_jump) begin
                  r_pc <= bus.i_target;
               end else if (bus.i_branch && bus.i_taken) begin
                  r_pc <= bus.i_target;
               end else begin
                  r_pc <= r_pc + PCW'(1);
               end
            end
            S_DONE: begin
               if (bus.i_start) begin
                  r_state     <= S_RUN;
                  r_pc        <= '0;
                  r_cycle_cnt <= '0;
                  r_done      <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_pc          = r_pc;
   assign bus.o_instr       = w_run ? bus.i_rom_data : '0;
   assign bus.o_instr_valid = w_run;
   assign bus.o_done        = r_done;
   assign bus.o_cycle_cnt   = r_cycle_cnt;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed bench for fetch_sequencer (default and PCW=4/CNTW=4 instances)
module tb_fetch_sequencer;
   localparam logic [8:0] HALT = 9'h1FF;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   logic [8:0] rom_a [0:1023];
   logic [8:0] rom_b [0:15];

   fetch_sequencer_if #(.PCW(10), .IW(9), .CNTW(16)) bus_a ();
   fetch_sequencer_if #(.PCW(4),  .IW(9), .CNTW(4))  bus_b ();

   fetch_sequencer #(.PCW(10), .IW(9), .HALT(HALT), .CNTW(16)) dut_a (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus_a.slave)
   );

   fetch_sequencer #(.PCW(4), .IW(9), .HALT(HALT), .CNTW(4)) dut_b (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus_b.slave)
   );

   assign bus_a.i_rom_data = rom_a[bus_a.o_pc];
   assign bus_b.i_rom_data = rom_b[bus_b.o_pc];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 1024; i++) rom_a[i] = 9'h000;
      for (int i = 0; i < 16; i++)   rom_b[i] = 9'h000;
      rom_a[0] = 9'h011;
      rom_a[1] = 9'h022;
      rom_a[2] = 9'h033;
      rom_a[3] = HALT;

      bus_a.i_start = 0; bus_a.i_branch = 0; bus_a.i_jump = 0;
      bus_a.i_taken = 0; bus_a.i_target = '0; bus_a.i_stall = 0;
      bus_b.i_start = 0; bus_b.i_branch = 0; bus_b.i_jump = 0;
      bus_b.i_taken = 0; bus_b.i_target = '0; bus_b.i_stall = 0;

      reset = 1;
      step(); step();
      reset = 0;
      check("rst_pc",    bus_a.o_pc, 0);
      check("rst_done",  bus_a.o_done, 0);
      check("rst_cnt",   bus_a.o_cycle_cnt, 0);
      check("rst_valid", bus_a.o_instr_valid, 0);
      check("rst_instr", bus_a.o_instr, 0);

      // Straight-line run to HALT at address 3
      bus_a.i_start = 1;
      step();
      bus_a.i_start = 0;
      check("run0_pc",    bus_a.o_pc, 0);
      check("run0_valid", bus_a.o_instr_valid, 1);
      check("run0_instr", bus_a.o_instr, 9'h011);
      check("run0_cnt",   bus_a.o_cycle_cnt, 0);
      step();
      check("run1_pc",  bus_a.o_pc, 1);
      check("run1_cnt", bus_a.o_cycle_cnt, 1);
      step();
      check("run2_pc",    bus_a.o_pc, 2);
      check("run2_instr", bus_a.o_instr, 9'h033);
      step();
      check("halt_pc",    bus_a.o_pc, 3);
      check("halt_instr", bus_a.o_instr, HALT);
      check("halt_valid", bus_a.o_instr_valid, 1);
      check("halt_done",  bus_a.o_done, 0);
      step();
      check("done_done",  bus_a.o_done, 1);
      check("done_cnt",   bus_a.o_cycle_cnt, 4);
      check("done_pc",    bus_a.o_pc, 3);
      check("done_valid", bus_a.o_instr_valid, 0);
      check("done_instr", bus_a.o_instr, 0);
      bus_a.i_stall = 1; bus_a.i_jump = 1; bus_a.i_target = 10'd99;
      step();
      bus_a.i_stall = 0; bus_a.i_jump = 0;
      check("done_hold_done", bus_a.o_done, 1);
      check("done_hold_pc",   bus_a.o_pc, 3);
      check("done_hold_cnt",  bus_a.o_cycle_cnt, 4);

      // Restart from DONE, then jump/branch priority
      rom_a[3] = 9'h000;
      bus_a.i_start = 1;
      step();
      bus_a.i_start = 0;
      check("restart_pc",   bus_a.o_pc, 0);
      check("restart_done", bus_a.o_done, 0);
      check("restart_cnt",  bus_a.o_cycle_cnt, 0);
      for (int i = 0; i < 5; i++) step();
      check("pre_jump_pc", bus_a.o_pc, 5);
      bus_a.i_jump = 1; bus_a.i_branch = 1; bus_a.i_taken = 0; bus_a.i_target = 10'd40;
      step();
      check("jump_pc", bus_a.o_pc, 40);
      bus_a.i_jump = 0; bus_a.i_branch = 1; bus_a.i_taken = 0; bus_a.i_target = 10'd77;
      step();
      check("br_nt_pc", bus_a.o_pc, 41);
      bus_a.i_branch = 1; bus_a.i_taken = 1; bus_a.i_target = 10'd7;
      step();
      check("br_t_pc", bus_a.o_pc, 7);
      bus_a.i_branch = 0; bus_a.i_taken = 0;
      step(); step();
      check("pre_stall_pc",  bus_a.o_pc, 9);
      check("pre_stall_cnt", bus_a.o_cycle_cnt, 10);

      // Stall two cycles at PC=9
      rom_a[9] = 9'h0AB;
      #1;
      check("stall0_instr", bus_a.o_instr, 9'h0AB);
      bus_a.i_stall = 1;
      step();
      check("stall1_pc",    bus_a.o_pc, 9);
      check("stall1_instr", bus_a.o_instr, 9'h0AB);
      step();
      check("stall2_pc",    bus_a.o_pc, 9);
      check("stall2_instr", bus_a.o_instr, 9'h0AB);
      bus_a.i_stall = 0;
      step();
      check("post_stall_pc",  bus_a.o_pc, 10);
      check("post_stall_cnt", bus_a.o_cycle_cnt, 13);

      // HALT under stall does not finish until stall drops
      rom_a[11] = HALT;
      step();
      check("sh_pc", bus_a.o_pc, 11);
      bus_a.i_stall = 1;
      step();
      check("sh_stall_done",  bus_a.o_done, 0);
      check("sh_stall_valid", bus_a.o_instr_valid, 1);
      check("sh_stall_pc",    bus_a.o_pc, 11);
      bus_a.i_stall = 0;
      step();
      check("sh_done", bus_a.o_done, 1);
      check("sh_pc2",  bus_a.o_pc, 11);
      check("sh_cnt",  bus_a.o_cycle_cnt, 16);

      // Reset mid-run at PC=12
      rom_a[11] = 9'h000;
      bus_a.i_start = 1;
      step();
      bus_a.i_start = 0;
      for (int i = 0; i < 12; i++) step();
      check("mid_pc", bus_a.o_pc, 12);
      reset = 1;
      step();
      reset = 0;
      check("mrst_pc",    bus_a.o_pc, 0);
      check("mrst_done",  bus_a.o_done, 0);
      check("mrst_cnt",   bus_a.o_cycle_cnt, 0);
      check("mrst_valid", bus_a.o_instr_valid, 0);
      step();
      check("idle_valid", bus_a.o_instr_valid, 0);
      bus_a.i_start = 1;
      step();
      bus_a.i_start = 0;
      check("rs_pc",    bus_a.o_pc, 0);
      check("rs_valid", bus_a.o_instr_valid, 1);
      step();
      check("rs_pc1", bus_a.o_pc, 1);

      // Start held through HALT: one-cycle Done then immediate restart
      rom_a[2] = HALT;
      bus_a.i_start = 1;
      step();
      check("hs_pc", bus_a.o_pc, 2);
      step();
      check("hs_done", bus_a.o_done, 1);
      step();
      check("hs_done_clr", bus_a.o_done, 0);
      check("hs_pc0",      bus_a.o_pc, 0);
      check("hs_cnt0",     bus_a.o_cycle_cnt, 0);
      check("hs_valid",    bus_a.o_instr_valid, 1);
      step();
      check("hs_pc1",  bus_a.o_pc, 1);
      check("hs_cnt1", bus_a.o_cycle_cnt, 1);
      bus_a.i_start = 0;
      rom_a[2] = 9'h000;

      // Narrow instance: PC wrap and counter saturation
      bus_b.i_start = 1;
      step();
      bus_b.i_start = 0;
      check("b_pc0", bus_b.o_pc, 0);
      for (int i = 0; i < 15; i++) step();
      check("b_pc15",  bus_b.o_pc, 15);
      check("b_cnt15", bus_b.o_cycle_cnt, 15);
      step();
      check("b_wrap_pc",    bus_b.o_pc, 0);
      check("b_wrap_valid", bus_b.o_instr_valid, 1);
      check("b_sat_cnt",    bus_b.o_cycle_cnt, 15);
      step();
      check("b_pc1",      bus_b.o_pc, 1);
      check("b_sat_cnt2", bus_b.o_cycle_cnt, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
